// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: single-entry skid register between the ALU and the
// register-file write port, plus the architectural shift-carry and parity flags.
module alu_writeback #(
    parameter int NREGS = 8,
    parameter int DW    = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wr,
    input  logic [AW-1:0] in_rd,
    input  logic [DW-1:0] rslt,
    input  logic          sc_o,
    input  logic          sc_en,
    input  logic          sc_clr,
    input  logic          pari,
    input  logic          pari_en,
    input  logic          pari_clr,
    input  logic          wb_stall,
    output logic          sc_q,
    output logic          pari_q,
    output logic          reg_we,
    output logic [AW-1:0] reg_waddr,
    output logic [DW-1:0] reg_wdata,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data,
    output logic [15:0]   retire_cnt
);

    logic          pend_v_r;
    logic          pend_wr_r;
    logic [AW-1:0] pend_rd_r;
    logic [DW-1:0] pend_data_r;
    logic          sc_r;
    logic          pari_r;
    logic [15:0]   retire_cnt_r;
    logic          acc_s;
    logic          ret_s;
    logic          ready_s;

    // Clear beats load; with neither strobe the flag keeps its value.
    function automatic logic flag_next(input logic q, input logic clr,
                                       input logic en, input logic d);
        logic n;
        if (clr) begin
            n = 1'b0;
        end else if (en) begin
            n = d;
        end else begin
            n = q;
        end
        return n;
    endfunction

    // Handshake decode; ready depends only on slot occupancy and the stall.
    always_comb begin
        ready_s = !pend_v_r || !wb_stall;
        acc_s   = in_valid && ready_s;
        ret_s   = pend_v_r && !wb_stall;
    end

    // Pending entry: a same-cycle accept replaces the retiring entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_r    <= 1'b0;
            pend_wr_r   <= 1'b0;
            pend_rd_r   <= '0;
            pend_data_r <= '0;
        end else if (acc_s) begin
            pend_v_r    <= 1'b1;
            pend_wr_r   <= in_wr;
            pend_rd_r   <= in_rd;
            pend_data_r <= rslt;
        end else if (ret_s) begin
            pend_v_r    <= 1'b0;
        end else begin
            pend_v_r    <= pend_v_r;
        end
    end

    // Flags follow accepted instructions only, so chained ALU ops see them next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_r   <= 1'b0;
            pari_r <= 1'b0;
        end else if (acc_s) begin
            sc_r   <= flag_next(sc_r, sc_clr, sc_en, sc_o);
            pari_r <= flag_next(pari_r, pari_clr, pari_en, pari);
        end else begin
            sc_r   <= sc_r;
            pari_r <= pari_r;
        end
    end

    // Retire counter, free-running modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 16'h0000;
        end else if (ret_s) begin
            retire_cnt_r <= retire_cnt_r + 16'h0001;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    // Output drive; write port and forwarding both present the pending fields.
    always_comb begin
        in_ready   = ready_s;
        reg_we     = ret_s && pend_wr_r;
        reg_waddr  = pend_rd_r;
        reg_wdata  = pend_data_r;
        fwd_valid  = pend_v_r && pend_wr_r;
        fwd_addr   = pend_rd_r;
        fwd_data   = pend_data_r;
        sc_q       = sc_r;
        pari_q     = pari_r;
        retire_cnt = retire_cnt_r;
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed test-plan scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_alu_writeback;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_wr;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] rslt;
    logic          sc_o, sc_en, sc_clr, pari, pari_en, pari_clr, wb_stall;
    logic          sc_q, pari_q, reg_we, fwd_valid;
    logic [AW-1:0] reg_waddr, fwd_addr;
    logic [DW-1:0] reg_wdata, fwd_data;
    logic [15:0]   retire_cnt;

    int checks   = 0;
    int failures = 0;
    int writes_seen;

    typedef struct {
        logic          wr;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t   m_q[$];
    logic     m_sc, m_pari;
    int       m_cnt;

    alu_writeback #(.NREGS(8), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_wr(in_wr), .in_rd(in_rd), .rslt(rslt),
        .sc_o(sc_o), .sc_en(sc_en), .sc_clr(sc_clr),
        .pari(pari), .pari_en(pari_en), .pari_clr(pari_clr),
        .wb_stall(wb_stall), .sc_q(sc_q), .pari_q(pari_q),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sc   = 1'b0;
        m_pari = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_wr = 1'b0; in_rd = '0; rslt = '0;
        sc_o = 1'b0; sc_en = 1'b0; sc_clr = 1'b0;
        pari = 1'b0; pari_en = 1'b0; pari_clr = 1'b0; wb_stall = 1'b0;
    endtask

    // Called just after a negedge with inputs set: checks outputs, advances one edge.
    task automatic cycle();
        logic   busy, ready, acc, ret;
        entry_t e;
        #1;
        busy  = (m_q.size() != 0);
        ready = !busy || !wb_stall;
        ret   = busy && !wb_stall;
        acc   = in_valid && ready;
        check("in_ready", in_ready, ready);
        check("reg_we", reg_we, ret && m_q[0].wr);
        check("fwd_valid", fwd_valid, busy && m_q[0].wr);
        check("sc_q", sc_q, m_sc);
        check("pari_q", pari_q, m_pari);
        check("retire_cnt", retire_cnt, m_cnt[15:0]);
        if (busy) begin
            check("fwd_addr", fwd_addr, m_q[0].rd);
            check("fwd_data", fwd_data, m_q[0].data);
        end
        if (ret && m_q[0].wr) begin
            check("reg_waddr", reg_waddr, m_q[0].rd);
            check("reg_wdata", reg_wdata, m_q[0].data);
        end
        if (reg_we) writes_seen++;
        @(posedge clk);
        if (ret) begin
            void'(m_q.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (acc) begin
            e.wr = in_wr; e.rd = in_rd; e.data = rslt;
            m_q.push_back(e);
            if (sc_clr) m_sc = 1'b0; else if (sc_en) m_sc = sc_o;
            if (pari_clr) m_pari = 1'b0; else if (pari_en) m_pari = pari;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_sc_q", sc_q, 1'b0);
        check("rst_pari_q", pari_q, 1'b0);
        check("rst_cnt", retire_cnt, 16'h0000);
        check("rst_fwd_addr", fwd_addr, 3'd0);
        check("rst_fwd_data", fwd_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        writes_seen = 0;
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Single write with shift-carry load.
        in_valid = 1'b1; in_wr = 1'b1; in_rd = 3'd3; rslt = 8'hA5; sc_en = 1'b1; sc_o = 1'b1;
        cycle();
        idle_inputs();
        #1;
        check("sw_fwd_valid", fwd_valid, 1'b1);
        check("sw_fwd_addr", fwd_addr, 3'd3);
        check("sw_reg_we", reg_we, 1'b1);
        check("sw_reg_wdata", reg_wdata, 8'hA5);
        check("sw_sc_q", sc_q, 1'b1);
        cycle();
        check("sw_cnt", retire_cnt, 16'd1);

        // Mid-stream reset with a pending entry and sc_q = 1.
        in_valid = 1'b1; in_wr = 1'b1; in_rd = 3'd5; rslt = 8'h11; wb_stall = 1'b1;
        cycle();
        cycle();
        idle_inputs();
        do_reset();

        // Flag priority, hold with no strobes, strobes ignored without valid.
        in_valid = 1'b1; sc_en = 1'b1; sc_o = 1'b1; sc_clr = 1'b1; pari_en = 1'b1; pari = 1'b1;
        cycle();
        #1;
        check("fp_sc_q", sc_q, 1'b0);
        check("fp_pari_q", pari_q, 1'b1);
        idle_inputs();
        in_valid = 1'b1;
        cycle();
        idle_inputs();
        sc_en = 1'b1; sc_o = 1'b1; pari_clr = 1'b1;
        cycle();
        cycle();
        check("fp_hold_sc", sc_q, 1'b0);
        check("fp_hold_pari", pari_q, 1'b1);

        // Stall with a pending entry while a new result waits.
        idle_inputs();
        in_valid = 1'b1; in_wr = 1'b1; in_rd = 3'd6; rslt = 8'h77;
        cycle();
        in_rd = 3'd2; rslt = 8'h3C; wb_stall = 1'b1; sc_en = 1'b1; sc_o = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("st_in_ready", in_ready, 1'b0);
            check("st_reg_we", reg_we, 1'b0);
            check("st_fwd_data", fwd_data, 8'h77);
            check("st_sc_q", sc_q, 1'b0);
            cycle();
        end
        wb_stall = 1'b0;
        #1;
        check("st_drop_we", reg_we, 1'b1);
        check("st_drop_wdata", reg_wdata, 8'h77);
        check("st_drop_ready", in_ready, 1'b1);
        cycle();
        idle_inputs();
        #1;
        check("st_new_data", fwd_data, 8'h3C);
        check("st_new_sc", sc_q, 1'b1);
        cycle();

        // Streaming: 20 back-to-back accepts, alternating writes.
        do_reset();
        writes_seen = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_wr = (i % 2 == 0); in_rd = AW'(i); rslt = DW'(i * 7 + 1);
            cycle();
        end
        idle_inputs();
        cycle();
        check("strm_writes", writes_seen, 32'd10);
        check("strm_cnt", retire_cnt, 16'd20);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_wr    = $urandom_range(0, 1);
            in_rd    = AW'($urandom);
            rslt     = DW'($urandom);
            sc_o     = $urandom_range(0, 1);
            sc_en    = $urandom_range(0, 1);
            sc_clr   = ($urandom_range(0, 3) == 0);
            pari     = $urandom_range(0, 1);
            pari_en  = $urandom_range(0, 1);
            pari_clr = ($urandom_range(0, 3) == 0);
            wb_stall = ($urandom_range(0, 2) == 0);
            cycle();
        end

        // Counter wrap after 65536 retires.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1; in_wr = i[0]; in_rd = AW'(i); rslt = DW'(i);
            cycle();
        end
        idle_inputs();
        cycle();
        check("wrap_cnt", retire_cnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
